// File: rtl/jtag_dmi_master.sv
// JTAG initiator for the RISC-V debug transport.
// Turns parallel DMI requests into IR/DR scans on a TAP and returns the DMI response.
// TCK is divided down from the system clock. TMS and TDI only move while TCK is low.
module jtag_dmi_master #(
    parameter int DEBUG_DATA_BITS = 34,
    parameter int DEBUG_ADDR_BITS = 5,
    parameter int DEBUG_OP_BITS   = 2,
    parameter int TCK_HALF        = 4,
    parameter int IDLE_CYCLES     = 2,
    parameter int MAX_RETRIES     = 15
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic                                                   req_valid,
    output logic                                                   req_ready,
    input  logic [DEBUG_ADDR_BITS+DEBUG_DATA_BITS+DEBUG_OP_BITS-1:0] req_data,
    output logic                                                   resp_valid,
    input  logic                                                   resp_ready,
    output logic [DEBUG_DATA_BITS+DEBUG_OP_BITS-1:0]               resp_data,
    output logic                                                   TCK,
    output logic                                                   TMS,
    output logic                                                   TDI,
    input  logic                                                   TDO,
    output logic                                                   TRST
);

    localparam int W   = DEBUG_ADDR_BITS + DEBUG_DATA_BITS + DEBUG_OP_BITS;
    localparam int RW  = DEBUG_DATA_BITS + DEBUG_OP_BITS;
    localparam int CW  = 16;
    localparam int RTW = $clog2(MAX_RETRIES + 2);
    localparam logic [4:0] IR_DMI = 5'b10001;

    typedef enum logic [3:0] {
        S_RESET_TAP, S_IDLE, S_IR_HDR, S_IR_SHIFT, S_IR_TAIL,
        S_DR_HDR, S_DR_SHIFT, S_DR_TAIL, S_CHECK, S_RESP
    } state_e;

    state_e            r_state;
    state_e            w_next;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_div;
    logic              r_tck;
    logic              r_irLoaded;
    logic              r_collect;
    logic [RTW-1:0]    r_retry;
    logic [W-1:0]      r_req;
    logic [W-1:0]      r_shift;
    logic [RW-1:0]     r_capt;
    logic [RW-1:0]     r_respData;

    logic [CW-1:0]     w_len;
    logic              w_tckActive;
    logic              w_tick;
    logic              w_rise;
    logic              w_fall;
    logic              w_last;
    logic              w_busy;
    logic              w_timeout;

    // Number of TCKs each scan state lasts, and the TCK edge strobes derived from the divider
    always_comb begin
        w_len = CW'(1);
        case (r_state)
            S_RESET_TAP: w_len = CW'(6);
            S_IR_HDR:    w_len = CW'(4);
            S_IR_SHIFT:  w_len = CW'(5);
            S_IR_TAIL:   w_len = CW'(2);
            S_DR_HDR:    w_len = CW'(3);
            S_DR_SHIFT:  w_len = CW'(W);
            S_DR_TAIL:   w_len = CW'(2 + IDLE_CYCLES);
            default:     w_len = CW'(1);
        endcase
        w_tckActive = !(r_state == S_IDLE || r_state == S_CHECK || r_state == S_RESP);
        w_tick      = w_tckActive && (r_div == CW'(TCK_HALF - 1));
        w_rise      = w_tick && !r_tck;
        w_fall      = w_tick && r_tck;
        w_last      = (r_cnt == w_len - CW'(1));
        w_busy      = (r_capt[DEBUG_OP_BITS-1:0] == {DEBUG_OP_BITS{1'b1}});
        w_timeout   = w_busy && (r_retry == RTW'(MAX_RETRIES));
    end

    // State register plus divider, scan shifters, retry bookkeeping and response capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_RESET_TAP;
            r_cnt      <= '0;
            r_div      <= '0;
            r_tck      <= 1'b0;
            r_irLoaded <= 1'b0;
            r_collect  <= 1'b0;
            r_retry    <= '0;
            r_req      <= '0;
            r_shift    <= '0;
            r_capt     <= '0;
            r_respData <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_fall) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_tckActive) begin
                if (w_tick) begin
                    r_div <= '0;
                    r_tck <= ~r_tck;
                end else begin
                    r_div <= r_div + CW'(1);
                end
            end else begin
                r_div <= '0;
                r_tck <= 1'b0;
            end
            if (r_state == S_IDLE && req_valid) begin
                r_req     <= req_data;
                r_collect <= 1'b0;
                r_retry   <= '0;
            end
            if (r_state == S_DR_HDR && w_fall && w_last) begin
                r_shift <= r_collect ? '0 : r_req;
            end else if (r_state == S_DR_SHIFT && w_fall) begin
                r_shift <= r_shift >> 1;
            end
            // only the data/resp bits of the capture matter; the address bits shift past unused
            if (r_state == S_DR_SHIFT && w_rise && r_cnt < CW'(RW)) begin
                r_capt <= {TDO, r_capt[RW-1:1]};
            end
            if (r_state == S_IR_TAIL && w_fall && w_last) begin
                r_irLoaded <= 1'b1;
            end
            if (r_state == S_CHECK) begin
                if (w_timeout) begin
                    r_respData <= {{DEBUG_DATA_BITS{1'b0}}, {DEBUG_OP_BITS{1'b1}}};
                    r_irLoaded <= 1'b0;
                end else if (w_busy) begin
                    r_retry <= r_retry + RTW'(1);
                end else if (!r_collect) begin
                    r_collect <= 1'b1;
                end else begin
                    r_respData <= r_capt;
                end
            end
        end
    end

    // Next-state selection; scan states advance on the TCK falling edge of their last bit
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET_TAP: if (w_fall && w_last) w_next = S_IDLE;
            S_IDLE:      if (req_valid) w_next = r_irLoaded ? S_DR_HDR : S_IR_HDR;
            S_IR_HDR:    if (w_fall && w_last) w_next = S_IR_SHIFT;
            S_IR_SHIFT:  if (w_fall && w_last) w_next = S_IR_TAIL;
            S_IR_TAIL:   if (w_fall && w_last) w_next = S_DR_HDR;
            S_DR_HDR:    if (w_fall && w_last) w_next = S_DR_SHIFT;
            S_DR_SHIFT:  if (w_fall && w_last) w_next = S_DR_TAIL;
            S_DR_TAIL:   if (w_fall && w_last) w_next = S_CHECK;
            S_CHECK: begin
                if (w_timeout) begin
                    w_next = S_RESP;
                end else if (w_busy || !r_collect) begin
                    w_next = S_DR_HDR;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_RESP:      if (resp_ready) w_next = S_IDLE;
            default:     w_next = S_RESET_TAP;
        endcase
    end

    // JTAG pin and handshake outputs decoded from state and bit position
    always_comb begin
        TMS        = 1'b0;
        TDI        = 1'b0;
        TRST       = 1'b0;
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        case (r_state)
            S_RESET_TAP: begin
                TMS  = (r_cnt != CW'(5));
                TRST = (r_cnt == CW'(0));
            end
            S_IR_HDR:    TMS = (r_cnt < CW'(2));
            S_IR_SHIFT: begin
                TMS = w_last;
                TDI = IR_DMI[r_cnt[2:0]];
            end
            S_IR_TAIL:   TMS = (r_cnt == CW'(0));
            S_DR_HDR:    TMS = (r_cnt == CW'(0));
            S_DR_SHIFT: begin
                TMS = w_last;
                TDI = r_shift[0];
            end
            S_DR_TAIL:   TMS = (r_cnt == CW'(0));
            default:     TMS = 1'b0;
        endcase
    end

    assign TCK       = r_tck;
    assign resp_data = r_respData;

endmodule

// File: tb/tb_jtag_dmi_master.sv
// Directed bench for jtag_dmi_master, driving it against a small TAP + DMI target model.
module tb_jtag_dmi_master;

    localparam logic [33:0] READ_DATA = 34'h2_0000_0003;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [40:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [35:0] resp_data;
    logic        TCK, TMS, TDI, TDO, TRST;

    int tests = 0;
    int fails = 0;

    jtag_dmi_master dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TRST(TRST)
    );

    always #5 clock = ~clock;

    // TAP controller model of the target
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDDR,
        SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR
    } tap_e;

    function automatic tap_e tapNext(input tap_e s, input logic tms);
        case (s)
            TLR:   return tms ? TLR   : RTI;
            RTI:   return tms ? SELDR : RTI;
            SELDR: return tms ? SELIR : CAPDR;
            CAPDR: return tms ? EX1DR : SHDR;
            SHDR:  return tms ? EX1DR : SHDR;
            EX1DR: return tms ? UPDDR : PAUDR;
            PAUDR: return tms ? EX2DR : PAUDR;
            EX2DR: return tms ? UPDDR : SHDR;
            UPDDR: return tms ? SELDR : RTI;
            SELIR: return tms ? TLR   : CAPIR;
            CAPIR: return tms ? EX1IR : SHIR;
            SHIR:  return tms ? EX1IR : SHIR;
            EX1IR: return tms ? UPDIR : PAUIR;
            PAUIR: return tms ? EX2IR : PAUIR;
            EX2IR: return tms ? UPDIR : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    tap_e        tap = TLR;
    logic [4:0]  irSr = '0;
    logic [4:0]  ir = 5'h01;
    logic [40:0] drSr = '0;
    logic [40:0] drLog [0:63];
    int          irScans = 0;
    int          drScans = 0;
    logic        pending = 1'b0;
    logic [1:0]  pendOp = '0;
    int          collectCount = 0;
    logic [33:0] lastData = '0;
    logic        alwaysBusy = 1'b0;
    int          busyCollects = 0;

    assign TDO = (tap == SHIR) ? irSr[0] : drSr[0];

    // TAP + DMI behaviour: busy responses, pending operation and read data
    always @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            tap <= TLR;
            ir  <= 5'h01;
        end else begin
            tap <= tapNext(tap, TMS);
            case (tap)
                CAPIR: irSr <= 5'h01;
                SHIR:  irSr <= {TDI, irSr[4:1]};
                UPDIR: begin
                    ir      <= irSr;
                    irScans <= irScans + 1;
                end
                CAPDR: begin
                    if (ir != 5'h11) begin
                        drSr <= '0;
                    end else if (alwaysBusy) begin
                        drSr <= {5'h1F, 34'h0, 2'b11};
                    end else if (pending && collectCount < busyCollects) begin
                        collectCount <= collectCount + 1;
                        drSr <= {5'h1F, 34'h0, 2'b11};
                    end else if (pending) begin
                        pending  <= 1'b0;
                        lastData <= (pendOp == 2'd1) ? READ_DATA : 34'h0;
                        drSr     <= {5'h1F, (pendOp == 2'd1) ? READ_DATA : 34'h0, 2'b00};
                    end else begin
                        drSr <= {5'h1F, lastData, 2'b00};
                    end
                end
                SHDR:  drSr <= {TDI, drSr[40:1]};
                UPDDR: begin
                    if (ir == 5'h11) begin
                        drLog[drScans % 64] <= drSr;
                        drScans <= drScans + 1;
                        if (!alwaysBusy && !pending && (drSr[1:0] == 2'd1 || drSr[1:0] == 2'd2)) begin
                            pending      <= 1'b1;
                            pendOp       <= drSr[1:0];
                            collectCount <= 0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pin activity monitors: TCK rises, TMS history, TRST at rise, response cycles, pin stability
    int         tckRises = 0;
    int         trstRises = 0;
    logic [5:0] tmsLog = '0;
    int         respCycles = 0;
    int         violations = 0;
    logic       prevTck = 1'b0;
    logic [1:0] prevPins = '0;

    always @(posedge TCK) begin
        tckRises <= tckRises + 1;
        tmsLog   <= {tmsLog[4:0], TMS};
        if (TRST) trstRises <= trstRises + 1;
    end

    always @(posedge clock) begin
        if (resp_valid) respCycles <= respCycles + 1;
    end

    always @(negedge clock) begin
        if (prevTck && TCK && ({TMS, TDI} !== prevPins)) violations <= violations + 1;
        prevTck  <= TCK;
        prevPins <= {TMS, TDI};
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, 64'(req_ready), 64'd1);
    endtask

    // Issue one request, then hold off resp_ready briefly to confirm the response is held
    task automatic applyStimulus(input string tag, input logic [4:0] addr, input logic [33:0] data,
                                 input logic [1:0] op, output logic [35:0] resp);
        int n = 0;
        waitReady({tag, "_ready"});
        req_data  = {addr, data, op};
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        req_data  = '0;
        while (resp_valid !== 1'b1 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, "_respValid"}, 64'(resp_valid), 64'd1);
        resp = resp_data;
        repeat (3) @(negedge clock);
        checkOutput({tag, "_respHeld"}, 64'({resp_valid, resp_data}), 64'({1'b1, resp}));
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    // Directed sequence: TAP reset, read, write, busy collects, timeout, IR rescan, mid-scan reset
    initial begin
        logic [35:0] resp;
        int irBase, drBase, tckBase, trstBase, respBase, n;

        reset = 1'b0; req_valid = 1'b0; req_data = '0; resp_ready = 1'b0;
        #3 reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("rst_TCK", 64'(TCK), 64'd0);
        checkOutput("rst_TMS", 64'(TMS), 64'd1);
        checkOutput("rst_TDI", 64'(TDI), 64'd0);
        checkOutput("rst_TRST", 64'(TRST), 64'd1);
        checkOutput("rst_reqReady", 64'(req_ready), 64'd0);
        checkOutput("rst_respValid", 64'(resp_valid), 64'd0);
        checkOutput("rst_respData", 64'(resp_data), 64'd0);

        tckBase = tckRises; trstBase = trstRises;
        reset = 1'b0;
        waitReady("init_ready");
        checkOutput("init_tckCount", 64'(tckRises - tckBase), 64'd6);
        checkOutput("init_trstTcks", 64'(trstRises - trstBase), 64'd1);
        checkOutput("init_tmsSeq", 64'(tmsLog), 64'b111110);
        checkOutput("init_tapIdle", 64'(tap), 64'(RTI));

        irBase = irScans; drBase = drScans;
        applyStimulus("rd1", 5'h10, 34'h0, 2'd1, resp);
        checkOutput("rd1_irScans", 64'(irScans - irBase), 64'd1);
        checkOutput("rd1_irValue", 64'(ir), 64'h11);
        checkOutput("rd1_drScans", 64'(drScans - drBase), 64'd2);
        checkOutput("rd1_reqWord", 64'(drLog[drBase % 64]), 64'({5'h10, 34'h0, 2'b01}));
        checkOutput("rd1_nopWord", 64'(drLog[(drBase + 1) % 64]), 64'd0);
        checkOutput("rd1_resp", 64'(resp), 64'({READ_DATA, 2'b00}));

        irBase = irScans; drBase = drScans;
        applyStimulus("wr2", 5'h05, 34'h1_2345_6789, 2'd2, resp);
        checkOutput("wr2_irScans", 64'(irScans - irBase), 64'd0);
        checkOutput("wr2_drScans", 64'(drScans - drBase), 64'd2);
        checkOutput("wr2_reqWord", 64'(drLog[drBase % 64]), 64'({5'h05, 34'h1_2345_6789, 2'b10}));
        checkOutput("wr2_resp", 64'(resp), 64'd0);

        busyCollects = 3;
        drBase = drScans;
        applyStimulus("busy3", 5'h10, 34'h0, 2'd1, resp);
        checkOutput("busy3_drScans", 64'(drScans - drBase), 64'd5);
        checkOutput("busy3_resp", 64'(resp), 64'({READ_DATA, 2'b00}));
        busyCollects = 0;

        alwaysBusy = 1'b1;
        drBase = drScans;
        applyStimulus("tmo", 5'h10, 34'h0, 2'd1, resp);
        checkOutput("tmo_drScans", 64'(drScans - drBase), 64'd16);
        checkOutput("tmo_resp", 64'(resp), 64'({34'h0, 2'b11}));
        alwaysBusy = 1'b0;

        irBase = irScans;
        applyStimulus("rescan", 5'h10, 34'h0, 2'd1, resp);
        checkOutput("rescan_irScans", 64'(irScans - irBase), 64'd1);
        checkOutput("rescan_resp", 64'(resp), 64'({READ_DATA, 2'b00}));

        waitReady("abort_ready");
        req_data  = {5'h10, 34'h0, 2'b01};
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        n = 0;
        while (tap != SHDR && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checkOutput("abort_inShift", 64'(tap), 64'(SHDR));
        repeat (40) @(negedge clock);
        respBase = respCycles;
        reset = 1'b1;
        #1;
        checkOutput("abort_pins", 64'({TCK, TMS, TDI, TRST, req_ready, resp_valid}), 64'b010100);
        checkOutput("abort_respData", 64'(resp_data), 64'd0);
        repeat (3) @(negedge clock);
        tckBase = tckRises; trstBase = trstRises;
        reset = 1'b0;
        waitReady("abort_reReady");
        checkOutput("abort_tckCount", 64'(tckRises - tckBase), 64'd6);
        checkOutput("abort_trstTcks", 64'(trstRises - trstBase), 64'd1);
        checkOutput("abort_tmsSeq", 64'(tmsLog), 64'b111110);
        checkOutput("abort_noResp", 64'(respCycles - respBase), 64'd0);

        checkOutput("pinStability", 64'(violations), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
